// File: rtl/hash_row_reorder_xbar.sv
// Reorder crossbar: routes tagged per-PE hash results into aligned issue rows, one row per beat out.
// Optional REORDER_XBAR_DEBUG_DISPLAY_EN prints every accepted output row lane by lane.
module hash_row_reorder_xbar #(
  parameter int unsigned NUM_HASH_PE          = 32,
  parameter int unsigned HASH_ISSUE_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH           = 32,
  parameter int unsigned META_MATCH_LEN_WIDTH = 5
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          input_valid,
  input  logic [NUM_HASH_PE-1:0]                        input_mask,
  input  logic [NUM_HASH_PE*ADDR_WIDTH-1:0]             input_addr,
  input  logic [NUM_HASH_PE-1:0]                        input_history_valid,
  input  logic [NUM_HASH_PE*ADDR_WIDTH-1:0]             input_history_addr,
  input  logic [NUM_HASH_PE*META_MATCH_LEN_WIDTH-1:0]   input_meta_match_len,
  input  logic [NUM_HASH_PE-1:0]                        input_meta_match_can_ext,
  input  logic [NUM_HASH_PE-1:0]                        input_delim,
  input  logic [NUM_HASH_PE*8-1:0]                      input_data,
  output logic                                          input_ready,
  output logic                                          output_valid,
  output logic [ADDR_WIDTH-1:0]                         output_head_addr,
  output logic [HASH_ISSUE_WIDTH-1:0]                   output_row_valid,
  output logic [HASH_ISSUE_WIDTH-1:0]                   output_history_valid,
  output logic [HASH_ISSUE_WIDTH*ADDR_WIDTH-1:0]        output_history_addr,
  output logic [HASH_ISSUE_WIDTH*META_MATCH_LEN_WIDTH-1:0] output_meta_match_len,
  output logic [HASH_ISSUE_WIDTH-1:0]                   output_meta_match_can_ext,
  output logic                                          output_delim,
  output logic [HASH_ISSUE_WIDTH*8-1:0]                 output_data,
  input  logic                                          output_ready
);

  localparam int unsigned NP         = NUM_HASH_PE;
  localparam int unsigned IW         = HASH_ISSUE_WIDTH;
  localparam int unsigned AW         = ADDR_WIDTH;
  localparam int unsigned MW         = META_MATCH_LEN_WIDTH;
  localparam int unsigned ISSUE_LOG2 = $clog2(HASH_ISSUE_WIDTH);
  localparam logic [AW-1:0] LANE_MASK = AW'(HASH_ISSUE_WIDTH - 1);

  // Holding register H
  logic             h_valid_q, h_valid_d;
  logic [NP-1:0]    h_pend_q, h_pend_d;
  logic [NP*AW-1:0] h_addr_q, h_addr_d;
  logic [NP-1:0]    h_hv_q, h_hv_d;
  logic [NP*AW-1:0] h_ha_q, h_ha_d;
  logic [NP*MW-1:0] h_mml_q, h_mml_d;
  logic [NP-1:0]    h_ext_q, h_ext_d;
  logic [NP-1:0]    h_delim_q, h_delim_d;
  logic [NP*8-1:0]  h_data_q, h_data_d;

  // Output register O
  logic             o_valid_q, o_valid_d;
  logic [AW-1:0]    o_head_q, o_head_d;
  logic [IW-1:0]    o_rv_q, o_rv_d;
  logic [IW-1:0]    o_hv_q, o_hv_d;
  logic [IW*AW-1:0] o_ha_q, o_ha_d;
  logic [IW*MW-1:0] o_mml_q, o_mml_d;
  logic [IW-1:0]    o_ext_q, o_ext_d;
  logic             o_delim_q, o_delim_d;
  logic [IW*8-1:0]  o_data_q, o_data_d;

  // Pass results
  logic [AW-1:0]    head_c;
  logic [NP-1:0]    sel_c;
  logic [NP-1:0]    pend_left_c;
  logic [IW-1:0]    row_rv_c, row_hv_c, row_ext_c;
  logic [IW*AW-1:0] row_ha_c;
  logic [IW*MW-1:0] row_mml_c;
  logic [IW*8-1:0]  row_data_c;
  logic             row_delim_c;
  logic             load_o_c, pass_c, final_c, accept_c;

  // Pick the row of the lowest pending entry, then fill lanes first-come by index.
  always_comb begin
    logic              found;
    logic [IW-1:0]     lane_used;
    logic [AW-1:0]     addr_j;
    logic [ISSUE_LOG2-1:0] lane_j;
    found       = 1'b0;
    lane_used   = '0;
    head_c      = '0;
    sel_c       = '0;
    row_rv_c    = '0;
    row_hv_c    = '0;
    row_ext_c   = '0;
    row_ha_c    = '0;
    row_mml_c   = '0;
    row_data_c  = '0;
    row_delim_c = 1'b0;
    addr_j      = '0;
    lane_j      = '0;
    for (int unsigned j = 0; j < NP; j++) begin
      if (h_pend_q[j] && !found) begin
        found  = 1'b1;
        head_c = h_addr_q[j*AW +: AW] & ~LANE_MASK;
      end
    end
    for (int unsigned j = 0; j < NP; j++) begin
      addr_j = h_addr_q[j*AW +: AW];
      lane_j = addr_j[ISSUE_LOG2-1:0];
      if (h_pend_q[j] && ((addr_j & ~LANE_MASK) == head_c) && !lane_used[lane_j]) begin
        sel_c[j]                        = 1'b1;
        lane_used[lane_j]               = 1'b1;
        row_rv_c[lane_j]                = 1'b1;
        row_hv_c[lane_j]                = h_hv_q[j];
        row_ext_c[lane_j]               = h_ext_q[j];
        row_ha_c[32'(lane_j)*AW +: AW]  = h_ha_q[j*AW +: AW];
        row_mml_c[32'(lane_j)*MW +: MW] = h_mml_q[j*MW +: MW];
        row_data_c[32'(lane_j)*8 +: 8]  = h_data_q[j*8 +: 8];
        row_delim_c                     = row_delim_c | h_delim_q[j];
      end
    end
  end

  assign pend_left_c = h_pend_q & ~sel_c;
  assign load_o_c    = ~o_valid_q | output_ready;
  assign pass_c      = h_valid_q & load_o_c;
  assign final_c     = pass_c & (pend_left_c == '0);
  assign input_ready = ~h_valid_q | final_c;
  assign accept_c    = input_valid & input_ready;

  // Next state for H and O; a fresh beat overrides the drained holding register.
  always_comb begin
    h_valid_d = h_valid_q;
    h_pend_d  = h_pend_q;
    h_addr_d  = h_addr_q;
    h_hv_d    = h_hv_q;
    h_ha_d    = h_ha_q;
    h_mml_d   = h_mml_q;
    h_ext_d   = h_ext_q;
    h_delim_d = h_delim_q;
    h_data_d  = h_data_q;
    o_valid_d = o_valid_q;
    o_head_d  = o_head_q;
    o_rv_d    = o_rv_q;
    o_hv_d    = o_hv_q;
    o_ha_d    = o_ha_q;
    o_mml_d   = o_mml_q;
    o_ext_d   = o_ext_q;
    o_delim_d = o_delim_q;
    o_data_d  = o_data_q;
    if (pass_c) begin
      h_pend_d  = pend_left_c;
      h_valid_d = |pend_left_c;
    end
    if (accept_c) begin
      h_valid_d = |input_mask;
      h_pend_d  = input_mask;
      h_addr_d  = input_addr;
      h_hv_d    = input_history_valid;
      h_ha_d    = input_history_addr;
      h_mml_d   = input_meta_match_len;
      h_ext_d   = input_meta_match_can_ext;
      h_delim_d = input_delim;
      h_data_d  = input_data;
    end
    if (load_o_c) begin
      o_valid_d = pass_c;
      o_head_d  = pass_c ? head_c : '0;
      o_rv_d    = pass_c ? row_rv_c : '0;
      o_hv_d    = pass_c ? row_hv_c : '0;
      o_ha_d    = pass_c ? row_ha_c : '0;
      o_mml_d   = pass_c ? row_mml_c : '0;
      o_ext_d   = pass_c ? row_ext_c : '0;
      o_delim_d = pass_c & row_delim_c;
      o_data_d  = pass_c ? row_data_c : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_valid_q <= 1'b0;
      h_pend_q  <= '0;
      h_addr_q  <= '0;
      h_hv_q    <= '0;
      h_ha_q    <= '0;
      h_mml_q   <= '0;
      h_ext_q   <= '0;
      h_delim_q <= '0;
      h_data_q  <= '0;
      o_valid_q <= 1'b0;
      o_head_q  <= '0;
      o_rv_q    <= '0;
      o_hv_q    <= '0;
      o_ha_q    <= '0;
      o_mml_q   <= '0;
      o_ext_q   <= '0;
      o_delim_q <= 1'b0;
      o_data_q  <= '0;
    end else begin
      h_valid_q <= h_valid_d;
      h_pend_q  <= h_pend_d;
      h_addr_q  <= h_addr_d;
      h_hv_q    <= h_hv_d;
      h_ha_q    <= h_ha_d;
      h_mml_q   <= h_mml_d;
      h_ext_q   <= h_ext_d;
      h_delim_q <= h_delim_d;
      h_data_q  <= h_data_d;
      o_valid_q <= o_valid_d;
      o_head_q  <= o_head_d;
      o_rv_q    <= o_rv_d;
      o_hv_q    <= o_hv_d;
      o_ha_q    <= o_ha_d;
      o_mml_q   <= o_mml_d;
      o_ext_q   <= o_ext_d;
      o_delim_q <= o_delim_d;
      o_data_q  <= o_data_d;
    end
  end

  assign output_valid              = o_valid_q;
  assign output_head_addr          = o_head_q;
  assign output_row_valid          = o_rv_q;
  assign output_history_valid      = o_hv_q;
  assign output_history_addr       = o_ha_q;
  assign output_meta_match_len     = o_mml_q;
  assign output_meta_match_can_ext = o_ext_q;
  assign output_delim              = o_delim_q;
  assign output_data               = o_data_q;

`ifdef REORDER_XBAR_DEBUG_DISPLAY_EN
  always_ff @(posedge clk) begin
    if (o_valid_q && output_ready) begin
      for (int unsigned l = 0; l < IW; l++) begin
        $display("xbar row addr=%0d rv=%0d hv=%0d ha=%0d mml=%0d ext=%0d delim=%0d data=%0d",
                 o_head_q + AW'(l), o_rv_q[l], o_hv_q[l], o_ha_q[l*AW +: AW],
                 o_mml_q[l*MW +: MW], o_ext_q[l], o_delim_q, o_data_q[l*8 +: 8]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_hash_row_reorder_xbar.sv
// Scoreboard bench for hash_row_reorder_xbar with 4 PEs, 4 lanes, 16-bit addresses.
module tb_hash_row_reorder_xbar;

  localparam int unsigned NP = 4;
  localparam int unsigned IW = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned MW = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              input_valid;
  logic [NP-1:0]     input_mask;
  logic [NP*AW-1:0]  input_addr;
  logic [NP-1:0]     input_history_valid;
  logic [NP*AW-1:0]  input_history_addr;
  logic [NP*MW-1:0]  input_meta_match_len;
  logic [NP-1:0]     input_meta_match_can_ext;
  logic [NP-1:0]     input_delim;
  logic [NP*8-1:0]   input_data;
  logic              input_ready;
  logic              output_valid;
  logic [AW-1:0]     output_head_addr;
  logic [IW-1:0]     output_row_valid;
  logic [IW-1:0]     output_history_valid;
  logic [IW*AW-1:0]  output_history_addr;
  logic [IW*MW-1:0]  output_meta_match_len;
  logic [IW-1:0]     output_meta_match_can_ext;
  logic              output_delim;
  logic [IW*8-1:0]   output_data;
  logic              output_ready;

  hash_row_reorder_xbar #(
    .NUM_HASH_PE(NP), .HASH_ISSUE_WIDTH(IW), .ADDR_WIDTH(AW), .META_MATCH_LEN_WIDTH(MW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .input_valid(input_valid), .input_mask(input_mask), .input_addr(input_addr),
    .input_history_valid(input_history_valid), .input_history_addr(input_history_addr),
    .input_meta_match_len(input_meta_match_len), .input_meta_match_can_ext(input_meta_match_can_ext),
    .input_delim(input_delim), .input_data(input_data), .input_ready(input_ready),
    .output_valid(output_valid), .output_head_addr(output_head_addr),
    .output_row_valid(output_row_valid), .output_history_valid(output_history_valid),
    .output_history_addr(output_history_addr), .output_meta_match_len(output_meta_match_len),
    .output_meta_match_can_ext(output_meta_match_can_ext), .output_delim(output_delim),
    .output_data(output_data), .output_ready(output_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]   head;
    logic [IW-1:0]   rv;
    logic [IW*8-1:0] data;
    logic            delim;
  } row_t;

  row_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Side fields of an entry are an encoding of its data byte, so lanes can be checked from data alone.
  task automatic lane_fields(input row_t r, output logic [IW-1:0] hv, output logic [IW*AW-1:0] ha,
                             output logic [IW*MW-1:0] mml, output logic [IW-1:0] ext);
    logic [7:0] d;
    hv = '0; ha = '0; mml = '0; ext = '0;
    for (int l = 0; l < IW; l++) begin
      if (r.rv[l]) begin
        d = r.data[l*8 +: 8];
        hv[l]             = d[0];
        ha[l*AW +: AW]    = {8'h55, d};
        mml[l*MW +: MW]   = d[4:0];
        ext[l]            = d[1];
      end
    end
  endtask

  task automatic push(input logic [AW-1:0] head, input logic [IW-1:0] rv,
                      input logic [IW*8-1:0] data, input logic delim);
    row_t r;
    r.head = head; r.rv = rv; r.data = data; r.delim = delim;
    exp_q.push_back(r);
  endtask

  task automatic send(input logic [NP-1:0] mask, input logic [NP*AW-1:0] addrs,
                      input logic [NP*8-1:0] data, input logic [NP-1:0] delim);
    logic [7:0] d;
    logic       done;
    input_mask  = mask;
    input_addr  = addrs;
    input_data  = data;
    input_delim = delim;
    for (int i = 0; i < NP; i++) begin
      d = data[i*8 +: 8];
      input_history_valid[i]         = d[0];
      input_history_addr[i*AW +: AW] = {8'h55, d};
      input_meta_match_len[i*MW +: MW] = d[4:0];
      input_meta_match_can_ext[i]    = d[1];
    end
    input_valid = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (input_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    input_valid = 1'b0;
    if (!done) chk("send_timeout", 64'(done), 64'd1);
  endtask

  // Monitor: every accepted row is popped and compared against the scoreboard head.
  initial begin
    row_t r;
    logic [IW-1:0]    hv, ext;
    logic [IW*AW-1:0] ha;
    logic [IW*MW-1:0] mml;
    forever begin
      @(negedge clk);
      if (rst_n && output_valid && output_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_row: got head=0x%0h rv=0x%0h expected no row", output_head_addr, output_row_valid);
        end else begin
          r = exp_q.pop_front();
          lane_fields(r, hv, ha, mml, ext);
          chk("head", 64'(output_head_addr), 64'(r.head));
          chk("row_valid", 64'(output_row_valid), 64'(r.rv));
          chk("data", 64'(output_data), 64'(r.data));
          chk("delim", 64'(output_delim), 64'(r.delim));
          chk("hist_valid", 64'(output_history_valid), 64'(hv));
          chk("hist_addr", 64'(output_history_addr), 64'(ha));
          chk("match_len", 64'(output_meta_match_len), 64'(mml));
          chk("can_ext", 64'(output_meta_match_can_ext), 64'(ext));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    input_valid = 1'b0; input_mask = '0; input_addr = '0; input_history_valid = '0;
    input_history_addr = '0; input_meta_match_len = '0; input_meta_match_can_ext = '0;
    input_delim = '0; input_data = '0; output_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(output_valid), 64'd0);
    chk("rst_in_ready", 64'(input_ready), 64'd1);
    chk("rst_head", 64'(output_head_addr), 64'd0);
    chk("rst_row_valid", 64'(output_row_valid), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Aligned beat with latency check
    push(16'h0008, 4'b1111, 32'hA3A2A1A0, 1'b0);
    send(4'b1111, 64'h000B_000A_0009_0008, 32'hA3A2A1A0, 4'b0000);
    @(negedge clk);
    chk("lat_not_yet", 64'(output_valid), 64'd0);
    @(negedge clk);
    chk("lat_row", 64'(output_valid), 64'd1);
    @(posedge clk); #1;

    // Permuted lanes: entries 0..3 at 7,4,6,5
    push(16'h0004, 4'b1111, 32'hB0B2B3B1, 1'b0);
    send(4'b1111, 64'h0005_0006_0004_0007, 32'hB3B2B1B0, 4'b0000);

    // Cross-row split; holding register stays busy during the first pass
    push(16'h0004, 4'b1100, 32'hC1C00000, 1'b0);
    push(16'h0008, 4'b0011, 32'h0000C3C2, 1'b0);
    send(4'b1111, 64'h0009_0008_0007_0006, 32'hC3C2C1C0, 4'b0000);
    @(negedge clk);
    chk("split_in_ready", 64'(input_ready), 64'd0);
    @(posedge clk); #1;

    // Lane collision with delim on the last entry
    push(16'h0004, 4'b0011, 32'h0000D2D0, 1'b0);
    push(16'h0008, 4'b0001, 32'h000000D1, 1'b0);
    push(16'h000C, 4'b0001, 32'h000000D3, 1'b1);
    send(4'b1111, 64'h000C_0005_0008_0004, 32'hD3D2D1D0, 4'b1000);

    // Empty mask is dropped; partial mask ignores masked entries and their delim
    send(4'b0000, 64'h0001_0001_0001_0001, 32'h77777777, 4'b1111);
    push(16'h0020, 4'b0101, 32'h00820080, 1'b0);
    send(4'b0101, 64'h0033_0022_0031_0020, 32'h83828180, 4'b0010);

    // Address wrap across the top of the address space
    push(16'hFFFC, 4'b1100, 32'h91900000, 1'b0);
    push(16'h0000, 4'b0011, 32'h00009392, 1'b0);
    send(4'b1111, 64'h0001_0000_FFFF_FFFE, 32'h93929190, 4'b0000);

    for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(negedge clk);
    @(posedge clk); #1;

    // Backpressure: two beats offered while downstream is stalled
    output_ready = 1'b0;
    push(16'h0010, 4'b1111, 32'hE3E2E1E0, 1'b0);
    push(16'h0014, 4'b1111, 32'hF3F2F1F0, 1'b0);
    send(4'b1111, 64'h0013_0012_0011_0010, 32'hE3E2E1E0, 4'b0000);
    send(4'b1111, 64'h0017_0016_0015_0014, 32'hF3F2F1F0, 4'b0000);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_valid", 64'(output_valid), 64'd1);
      chk("bp_head", 64'(output_head_addr), 64'h10);
      chk("bp_data", 64'(output_data), 64'hE3E2E1E0);
      chk("bp_in_ready", 64'(input_ready), 64'd0);
    end
    @(posedge clk); #1;
    output_ready = 1'b1;
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(negedge clk);
    @(posedge clk); #1;

    // Reset while a split beat still has a row pending
    output_ready = 1'b0;
    send(4'b1111, 64'h0009_0008_0007_0006, 32'h73727170, 4'b0000);
    @(posedge clk); #1;
    chk("pre_rst_valid", 64'(output_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(output_valid), 64'd0);
    chk("mid_rst_row_valid", 64'(output_row_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(input_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    output_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_in_ready", 64'(input_ready), 64'd1);
    chk("post_rst_no_row", 64'(output_valid), 64'd0);
    @(posedge clk); #1;
    push(16'h0000, 4'b1111, 32'h13121110, 1'b0);
    send(4'b1111, 64'h0003_0002_0001_0000, 32'h13121110, 4'b0000);

    for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(negedge clk);
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
